// File: rtl/counter_arbiter_pkg.sv
// ============================================================================
// Module : counter_arbiter_pkg
// Brief  : Shared FSM state encoding and step-direction constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/counter_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector; scans last+1, last+2, ... mod NREQ.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import counter_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  winner,
  output logic            valid
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = '0;
    // Offset 1 is checked first so the previous owner has the lowest priority.
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = IDW'((int'(last) + i) % NREQ);
      if (!valid && req[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_arbiter.sv
// ============================================================================
// Module : counter_arbiter
// Brief  : Round-robin shared saturating up/down counter with ack/reject.
//          Define COUNTER_ARBITER_WRAP_EN for wrap-around instead of saturation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int BITS     = 4,
  parameter int MAX_VAL  = 2**BITS-1,
  parameter int INIT_VAL = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         dir,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [NREQ-1:0]         ack,
  output logic                    reject,
  output logic                    busy,
  output logic [BITS-1:0]         count,
  output logic                    full_flag,
  output logic                    empty_flag
);

  localparam int IDW = $clog2(NREQ);

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [IDW-1:0]  r_gnt_id;
  logic [IDW-1:0]  r_last;
  logic [NREQ-1:0] r_ack;
  logic            r_reject;
  logic            r_busy;
  logic            r_dir;
  logic [BITS-1:0] r_count;

  logic [IDW-1:0]  w_winner;
  logic            w_valid;
  logic [BITS-1:0] w_max;
  logic [NREQ-1:0] w_onehot;

  assign w_max    = BITS'(MAX_VAL);
  assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req    (req),
    .last   (r_last),
    .winner (w_winner),
    .valid  (w_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gnt_id <= '0;
      r_last   <= IDW'(NREQ-1);
      r_ack    <= '0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
      r_dir    <= 1'b0;
      r_count  <= BITS'(INIT_VAL);
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack    <= '0;
          r_reject <= 1'b0;
          if (enable && w_valid) begin
            r_grant  <= w_onehot;
            r_gnt_id <= w_winner;
            r_last   <= w_winner;
            r_dir    <= dir[w_winner];
            r_busy   <= 1'b1;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_ack   <= r_grant;
          r_state <= ST_WAIT;
          if (r_dir == DIR_UP) begin
            if (r_count == w_max) begin
`ifdef COUNTER_ARBITER_WRAP_EN
              r_count  <= '0;
              r_reject <= 1'b0;
`else
              r_reject <= 1'b1;
`endif
            end else begin
              r_count  <= r_count + BITS'(1);
              r_reject <= 1'b0;
            end
          end else begin
            if (r_count == '0) begin
`ifdef COUNTER_ARBITER_WRAP_EN
              r_count  <= w_max;
              r_reject <= 1'b0;
`else
              r_reject <= 1'b1;
`endif
            end else begin
              r_count  <= r_count - BITS'(1);
              r_reject <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          r_ack    <= '0;
          r_reject <= 1'b0;
          // Releasing only on a dropped request stops a held req from stepping twice.
          if (!req[r_gnt_id]) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant  <= '0;
          r_ack    <= '0;
          r_reject <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign gnt_id     = r_gnt_id;
  assign ack        = r_ack;
  assign reject     = r_reject;
  assign busy       = r_busy;
  assign count      = r_count;
  assign full_flag  = (r_count == w_max);
  assign empty_flag = (r_count == '0);

endmodule

`default_nettype wire

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares one saturating up/down counter between NREQ requesters; each requester asks for a single +1 or -1 step.
- A round-robin arbiter and a three-state FSM serialise the steps and complete each one with a one-cycle ack.
- Boundary violations are flagged with reject.
- Used as a shared credit/occupancy counter between independent agents.

Parameters:
- NREQ, 4, number of requesters (2..16)
- BITS, 4, counter width
- MAX_VAL, 2**BITS-1, upper bound of the counter (1..2**BITS-1)
- INIT_VAL, 0, counter value after reset (0..MAX_VAL)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  permits new grants; an operation already in flight always completes
- req  in  NREQ  per-requester level request; held until its ack
- dir  in  NREQ  per-requester step direction: 1 = up, 0 = down; sampled at grant
- grant  out  NREQ  one-hot current owner; 0 when idle
- gnt_id  out  $clog2(NREQ)  binary index of the owner
- ack  out  NREQ  one-hot, one-cycle completion pulse
- reject  out  1  qualifies ack: step refused at a bound
- busy  out  1  FSM not in IDLE
- count  out  BITS  counter value
- full_flag  out  1  count == MAX_VAL
- empty_flag  out  1  count == 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports named clock and reset.
- Reset values: count = INIT_VAL; grant, ack, reject, busy = 0; gnt_id = 0; state = IDLE; round-robin pointer last = NREQ-1, so req[0] has top priority.
- All outputs are registered except full_flag and empty_flag, which decode count combinationally.
- FSM states: IDLE, EXEC, WAIT.
- IDLE:
  - If enable and |req: winner = first set req scanning last+1, last+2, … (mod NREQ).
  - At the edge: grant <= onehot(winner), gnt_id <= winner, capture dir[winner], last <= winner, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (exactly one cycle):
  - up and count == MAX_VAL: count unchanged, reject <= 1.
  - down and count == 0: count unchanged, reject <= 1.
  - Otherwise count <= count ± 1, reject <= 0.
  - ack <= grant; go to WAIT.
- WAIT:
  - ack and reject are high for the first WAIT cycle only.
  - Stay in WAIT while req[gnt_id] == 1.
  - When req[gnt_id] == 0: grant <= 0, go to IDLE. This prevents a held request from double-stepping.
- Latency:
  - req sampled in cycle 0 → grant visible in cycle 1 → ack, reject and the new count visible in cycle 2.
  - If req drops in cycle 2, IDLE in cycle 3; the earliest next grant is visible in cycle 4.
  - Minimum 3 cycles per operation.
- Owner drops req during EXEC: the step still commits and ack still pulses.
- dir changes after grant: ignored; the value captured at grant is used.
- enable low: blocks only IDLE→EXEC; EXEC and WAIT proceed.
- Simultaneous requests: served strictly round-robin; a continuously requesting agent waits at most NREQ-1 operations.
- reset asserted mid-operation: immediate return to reset values; the in-flight step is lost with no ack.
- count never leaves [0, MAX_VAL].

Optional Feature:
- Macro: COUNTER_ARBITER_WRAP_EN.
- Defined:
  - up at MAX_VAL wraps to 0; down at 0 wraps to MAX_VAL.
  - reject is tied to 0.
- Undefined: saturating behaviour with reject, as above.
- Arbitration, handshake and latency are identical in both builds.

Decomposition:
- Shared package counter_arbiter_pkg:
  - state encoding ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_WAIT = 2'd2.
  - constants DIR_UP = 1'b1, DIR_DOWN = 1'b0.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req[NREQ], last index.
  - Outputs: winner index, valid.
- FSM and counter stay in counter_arbiter.

Test Plan (all scenarios use NREQ = 4, BITS = 4, MAX_VAL = 15, INIT_VAL = 0):
- Reset then single step: req[1] = 1, dir[1] = 1 in cycle 0 → grant = 4'b0010 in cycle 1; ack = 4'b0010, reject = 0, count = 1 in cycle 2; req dropped → busy = 0 in cycle 3.
- Round-robin fairness: req = 4'b1111 held, all dir = 1, each requester drops req on its ack and reraises it next cycle → grant order 0,1,2,3,0; count = 5 after five acks.
- Underflow: from reset, req[2] = 1, dir[2] = 0 → ack[2] with reject = 1, count stays 0, empty_flag = 1.
  - With COUNTER_ARBITER_WRAP_EN: count = 15, full_flag = 1, reject = 0.
- Overflow and hold: drive count to 15, then req[3] up and held 10 cycles → exactly one ack, reject = 1, count = 15, grant stays 4'b1000 until req[3] drops.
- enable gating and reset mid-op: enable = 0 with req = 4'b0001 → no grant for 5 cycles; enable = 1 → grant next cycle; assert reset during EXEC → count = 0, grant = 0, ack never pulses.
